// File: rtl/tone_capture.sv
// tone_capture: measures period and high time of a square-wave beeper line.
// A tone is published once two consecutive periods agree within TOL clocks;
// a lost tone is reported when the period counter saturates.
//
// Ports:
//   clk_in      system clock, all state on rising edge
//   rst_n_in    asynchronous active-low reset
//   beeper_in   asynchronous tone input
//   cycle_out   last accepted period in clocks (WIDTH)
//   duty_out    high time of the last accepted period in clocks (WIDTH)
//   tone_valid  one-clock pulse per accepted measurement
//   tone_on     high while a stable tone is present
//   timeout     one-clock pulse when an established tone is lost
module tone_capture #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned TOL        = 4,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             beeper_in,
  output logic [WIDTH-1:0] cycle_out,
  output logic [WIDTH-1:0] duty_out,
  output logic             tone_valid,
  output logic             tone_on,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_TRACK = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  // Value one below saturation: the increment out of it is the timeout event,
  // so a rise seen in that same cycle still measures (max period 2^WIDTH-2).
  localparam logic [WIDTH-1:0] CNT_PRE = CNT_MAX - WIDTH'(1);
  localparam logic [WIDTH-1:0] TOL_W   = WIDTH'(TOL);
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_PERIOD);

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cycle_q, cycle_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             on_q, on_d;
  logic             tout_q, tout_d;

  logic             rise, fall, sat, period_ok, match;
  logic [WIDTH-1:0] diff;

  // State registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      high_q  <= '0;
      ref_q   <= '0;
      cycle_q <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      on_q    <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      ref_q   <= ref_d;
      cycle_q <= cycle_d;
      duty_q  <= duty_d;
      valid_q <= valid_d;
      on_q    <= on_d;
      tout_q  <= tout_d;
    end
  end

  // Synchronizer, edge detect, period counter and measurement FSM
  always_comb begin
    sync1_d = beeper_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    rise = sync2_q & ~prev_q;
    fall = ~sync2_q & prev_q;

    if (rise) begin
      cnt_d = WIDTH'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Larger minus smaller, so the difference never wraps
    diff      = (cnt_q >= ref_q) ? (cnt_q - ref_q) : (ref_q - cnt_q);
    period_ok = (cnt_q >= MIN_W);
    match     = (diff <= TOL_W);
    sat       = (cnt_q == CNT_PRE);

    state_d = state_q;
    high_d  = high_q;
    ref_d   = ref_q;
    cycle_d = cycle_q;
    duty_d  = duty_q;
    on_d    = on_q;
    valid_d = 1'b0;
    tout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_FIRST;
        end
      end
      S_FIRST, S_TRACK: begin
        if (fall) begin
          high_d = cnt_q;
        end
        if (rise) begin
          if (period_ok) begin
            ref_d = cnt_q;
            if (state_q == S_FIRST) begin
              state_d = S_TRACK;
            end else if (match) begin
              cycle_d = cnt_q;
              duty_d  = high_q;
              valid_d = 1'b1;
              on_d    = 1'b1;
            end
          end
        end else if (sat) begin
          state_d = S_IDLE;
          cycle_d = '0;
          duty_d  = '0;
          on_d    = 1'b0;
          tout_d  = on_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cycle_out  = cycle_q;
  assign duty_out   = duty_q;
  assign tone_valid = valid_q;
  assign tone_on    = on_q;
  assign timeout    = tout_q;

endmodule
